// File: rtl/ffm.sv
// ffm: sequential modular multiplier over GF(P), P = 2^255 - 19.
// Computes result = (a * b) mod P by MSB-first interleaved double-and-add,
// with a conditional subtraction after every double and every add so the
// accumulator always stays below P.
//
// Optional build macro: FFM_RADIX4_EN
//   undefined : one multiplier bit per cycle, start-to-valid latency 256 edges
//   defined   : two multiplier bits per cycle, start-to-valid latency 129 edges
//   Results are bit-identical in both builds.
//
// Ports:
//   clk    in   1    rising-edge clock
//   rst    in   1    asynchronous, active-high reset
//   start  in   1    operation request, sampled only while busy = 0
//   a      in   N    multiplicand, any value 0..2^N-1 (reduced on capture)
//   b      in   N    multiplier, any value 0..2^N-1
//   result out  N    (a*b) mod P, held until the next completion
//   valid  out  1    one-cycle pulse when result updates
//   busy   out  1    high while an operation is in flight
module ffm #(
  parameter int unsigned  N = 255,
  parameter logic [255:0] P = (256'd1 << 255) - 256'd19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result,
  output logic         valid,
  output logic         busy
);

  // P fits in N bits, so every "x - P" whose true value is below P can be
  // done modulo 2^N; only the comparisons need the extra carry bit.
  localparam logic [N-1:0] P_N = P[N-1:0];
  localparam logic [N:0]   P_X = P[N:0];

`ifdef FFM_RADIX4_EN
  localparam int unsigned BW = N + 1;
  localparam int unsigned CW = 7;
  localparam logic [CW-1:0] CNT_MAX = CW'(BW / 2 - 1);
`else
  localparam int unsigned BW = N;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);
`endif
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [N-1:0]    r_ar;
  logic [BW-1:0]   r_br;
  logic [N-1:0]    r_acc;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_result;
  logic            r_valid;

  logic [N-1:0]    w_a_red;
  logic [BW-1:0]   w_b_ext;
  logic [N-1:0]    w_acc_next;
  logic            w_last;

  // One interleaved step: acc <- (2*acc [+ ar]) mod P, given acc, ar < P.
  function automatic logic [N-1:0] f_step(input logic [N-1:0] acc,
                                          input logic [N-1:0] ar,
                                          input logic         bit_i);
    logic [N:0]   d;
    logic [N-1:0] dr;
    logic [N:0]   s;
    logic [N-1:0] sr;
    d  = {acc, 1'b0};
    dr = (d >= P_X) ? (d[N-1:0] - P_N) : d[N-1:0];
    s  = {1'b0, dr} + {1'b0, ar};
    sr = (s >= P_X) ? (s[N-1:0] - P_N) : s[N-1:0];
    return bit_i ? sr : dr;
  endfunction

  // a < 2^N < 2P, so a single subtraction fully reduces it.
  assign w_a_red = (a >= P_N) ? (a - P_N) : a;

`ifdef FFM_RADIX4_EN
  assign w_b_ext = {1'b0, b};

  // Bit 2j+1 first, then bit 2j, keeping MSB-first order within the pair.
  always_comb begin
    w_acc_next = f_step(r_acc, r_ar, r_br[{r_cnt, 1'b1}]);
    w_acc_next = f_step(w_acc_next, r_ar, r_br[{r_cnt, 1'b0}]);
  end
`else
  assign w_b_ext = b;

  always_comb begin
    w_acc_next = f_step(r_acc, r_ar, r_br[r_cnt]);
  end
`endif

  assign w_last = (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ar     <= '0;
      r_br     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ar  <= w_a_red;
            r_br  <= w_b_ext;
            r_acc <= '0;
            r_cnt <= CNT_MAX;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          if (!w_last) r_cnt <= r_cnt - CNT_ONE;
        end
        S_DONE: begin
          r_result <= r_acc;
          r_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign valid  = r_valid;
  assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_ffm.sv
module tb_ffm;

  localparam logic [255:0] P  = (256'd1 << 255) - 256'd19;
  localparam logic [254:0] PN = P[254:0];
`ifdef FFM_RADIX4_EN
  localparam int LAT = 129;
`else
  localparam int LAT = 256;
`endif
  localparam int BOUND = LAT + 40;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [254:0] a;
  logic [254:0] b;
  logic [254:0] result;
  logic         valid;
  logic         busy;

  ffm dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .result (result),
    .valid  (valid),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_valid = 0;
  int n_acc = 0;
  logic [254:0] sb_q[$];

  typedef struct {
    string        name;
    logic [254:0] a;
    logic [254:0] b;
    logic [254:0] exp;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [254:0] act, input logic [254:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: full 510-bit product reduced with a true modulo.
  function automatic logic [254:0] ref_mul(input logic [254:0] x, input logic [254:0] y);
    logic [511:0] px;
    logic [511:0] r;
    px = {257'd0, x} * {257'd0, y};
    r  = px % {256'd0, P};
    return r[254:0];
  endfunction

  // Scoreboard: every valid pulse pops one expected product.
  always @(negedge clk) begin
    if (!rst && valid) begin
      n_valid++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got result %h want no valid", result);
      end else begin
        chk("result", result, sb_q.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge where valid is seen.
  task automatic wait_valid(output int n);
    n = 0;
    repeat (BOUND) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (valid) return;
    end
    total++;
    bad++;
    $display("FAIL timeout: got no valid in %0d cycles want valid", BOUND);
    n = -1;
  endtask

  // Called at a negedge with busy = 0.
  task automatic do_op(input logic [254:0] x, input logic [254:0] y,
                       input logic [254:0] exp, input string name);
    int n;
    a = x;
    b = y;
    start = 1'b1;
    sb_q.push_back(exp);
    n_acc++;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = ~x;
    b = ~y;
    chk({name, "_busy"}, 255'(busy), 255'(1));
    wait_valid(n);
    chk({name, "_latency"}, 255'(n), 255'(LAT));
    @(negedge clk);
    chk({name, "_valid_width"}, 255'(valid), 255'(0));
  endtask

  initial begin
    logic [254:0] x254;
    logic [254:0] allones;
    logic [254:0] x;
    logic [254:0] y;
    logic [255:0] t;
    int n;
    int m;
    int v0;

    x254    = 255'd1 << 254;
    allones = '1;
    tbl[0] = '{name: "mul_3_5",     a: 255'd3,     b: 255'd5,   exp: 255'd15};
    tbl[1] = '{name: "mul_pm1_pm1", a: PN - 1'b1,  b: PN - 1'b1, exp: 255'd1};
    tbl[2] = '{name: "mul_2p254_2", a: x254,       b: 255'd2,   exp: 255'd19};
    tbl[3] = '{name: "mul_pp1_7",   a: PN + 1'b1,  b: 255'd7,   exp: 255'd7};
    tbl[4] = '{name: "mul_0_max",   a: 255'd0,     b: allones,  exp: 255'd0};
    tbl[5] = '{name: "mul_max_1",   a: allones,    b: 255'd1,   exp: 255'd18};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    #1;
    chk("reset_result", result, 255'd0);
    chk("reset_valid", 255'(valid), 255'(0));
    chk("reset_busy", 255'(busy), 255'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].name);
    end

    // start while busy is ignored; start in the valid cycle is accepted
    a = 255'd3;
    b = 255'd5;
    start = 1'b1;
    sb_q.push_back(255'd15);
    n_acc++;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    a = 255'd9;
    b = 255'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ignored_start_busy", 255'(busy), 255'(1));
    wait_valid(n);
    chk("valid_cycle_not_busy", 255'(busy), 255'(0));
    a = 255'd4;
    b = 255'd6;
    start = 1'b1;
    sb_q.push_back(255'd24);
    n_acc++;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_valid(m);
    chk("b2b_gap", 255'(m + 1), 255'(LAT + 1));
    @(negedge clk);

    // asynchronous reset mid-operation aborts without a valid
    a = 255'd3;
    b = 255'd5;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_result", result, 255'd0);
    chk("abort_valid", 255'(valid), 255'(0));
    chk("abort_busy", 255'(busy), 255'(0));
    @(negedge clk);
    rst = 1'b0;
    v0 = n_valid;
    repeat (LAT + 20) @(negedge clk);
    chk("abort_no_valid", 255'(n_valid), 255'(v0));
    do_op(255'd2, 255'd3, 255'd6, "after_abort");

    // random operands and gaps against the reference model
    for (int i = 0; i < 120; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      t = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
      x = t[254:0];
      t = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
      y = t[254:0];
      if (i % 10 == 0) x = PN + 255'(x[3:0]);
      if (i % 17 == 0) y = PN - 255'(y[3:0]);
      do_op(x, y, ref_mul(x, y), "rand");
    end

    chk("queue_empty", 255'(sb_q.size()), 255'(0));
    chk("valid_count", 255'(n_valid), 255'(n_acc));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
